// File: rtl/bpsk_demodulator.sv
`timescale 1ns/1ps
// Coherent BPSK demodulator: product with a local reference, integrate-and-dump, sign slicer.
// Optional confidence flag o_data_weak is built when BPSK_DEMOD_CONF_EN is defined.
module bpsk_demodulator #(
    parameter int DATA_W     = 16,
    parameter int SPS        = 32,
    parameter int PROD_SHIFT = 15,
    parameter int ACC_W      = 32
`ifdef BPSK_DEMOD_CONF_EN
    ,
    parameter int CONF_THRESH = 1024
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clken,
    input  logic                     i_demod_ena,
    input  logic                     i_sym_start,
    input  logic signed [DATA_W-1:0] i_bpsk_in,
    input  logic signed [DATA_W-1:0] i_ref_sine,
    output logic                     o_data_out,
    output logic                     o_data_valid,
    output logic                     o_sync_err,
    output logic                     o_busy
`ifdef BPSK_DEMOD_CONF_EN
    ,
    output logic                     o_data_weak
`endif
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(SPS);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ALIGN     = 2'd1;
    localparam logic [1:0] INTEGRATE = 2'd2;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic                     r_prod_last;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_data_out;
    logic                     r_data_valid;
    logic                     r_sync_err;

    logic                     w_in_align;
    logic                     w_in_int;
    logic                     w_start;
    logic                     w_resync;
    logic                     w_accept;
    logic [CNT_W-1:0]         w_idx;
    logic                     w_idx_last;
    logic signed [PROD_W-1:0] w_mult;
    logic signed [PROD_W-1:0] w_prod_sh;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_sum_pos;
    logic                     w_stage2;

    assign w_in_align = (r_state == ALIGN);
    assign w_in_int   = (r_state == INTEGRATE);
    assign w_start    = i_clken & i_sym_start & w_in_align;
    assign w_resync   = i_demod_ena & i_clken & i_sym_start & w_in_int & (r_cnt != '0);
    assign w_accept   = i_demod_ena & i_clken & (w_in_int | w_start);

    // A symbol start (first lock or resync) forces the sample index back to 0.
    assign w_idx      = (w_start | w_resync) ? '0 : r_cnt;
    assign w_idx_last = (w_idx == CNT_W'(SPS - 1));

    assign w_mult     = i_bpsk_in * i_ref_sine;
    assign w_prod_sh  = r_prod >>> PROD_SHIFT;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign w_prod_ext = {{(ACC_W - PROD_W){w_prod_sh[PROD_W-1]}}, w_prod_sh};
        end else if (ACC_W == PROD_W) begin : g_same
            assign w_prod_ext = w_prod_sh;
        end else begin : g_trunc
            assign w_prod_ext = w_prod_sh[ACC_W-1:0];
        end
    endgenerate

    assign w_sum     = r_acc + w_prod_ext;
    assign w_sum_pos = ~w_sum[ACC_W-1] & (w_sum != '0);
    // A resync abandons the symbol, so the product still in flight is dropped.
    assign w_stage2  = i_demod_ena & r_prod_vld & ~w_resync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (!i_demod_ena) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:      r_state <= ALIGN;
                ALIGN:     r_state <= w_start ? INTEGRATE : ALIGN;
                INTEGRATE: r_state <= INTEGRATE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_prod_last <= 1'b0;
        end else if (!i_demod_ena) begin
            r_cnt       <= '0;
            r_prod_vld  <= 1'b0;
            r_prod_last <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod      <= w_mult;
                r_prod_last <= w_idx_last;
                r_cnt       <= w_idx_last ? '0 : w_idx + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            if (!i_demod_ena) begin
                r_acc <= '0;
            end else if (w_resync) begin
                r_acc      <= '0;
                r_sync_err <= 1'b1;
            end else if (w_stage2) begin
                if (r_prod_last) begin
                    r_acc        <= '0;
                    r_data_out   <= w_sum_pos;
                    r_data_valid <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

`ifdef BPSK_DEMOD_CONF_EN
    logic [ACC_W-1:0] w_abs_sum;
    logic             r_data_weak;

    assign w_abs_sum = w_sum[ACC_W-1] ? -w_sum : w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_weak <= 1'b0;
        end else if (w_stage2 && r_prod_last) begin
            r_data_weak <= (w_abs_sum < ACC_W'(CONF_THRESH));
        end
    end

    assign o_data_weak = r_data_weak;
`endif

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_sync_err   = r_sync_err;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bpsk_demodulator.sv
`timescale 1ns/1ps
// Scoreboard bench for bpsk_demodulator: stimulus pushes expected decisions, a negedge monitor pops them.
module tb_bpsk_demodulator;
    localparam int DATA_W = 16;
    localparam int SPS    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clken = 1'b0;
    logic ena = 1'b0;
    logic ss = 1'b0;
    logic signed [DATA_W-1:0] bpsk = '0;
    logic signed [DATA_W-1:0] refs = '0;
    logic data_out, data_valid, sync_err, busy;
`ifdef BPSK_DEMOD_CONF_EN
    logic data_weak;
`endif

    bpsk_demodulator #(.DATA_W(DATA_W), .SPS(SPS), .PROD_SHIFT(15), .ACC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_clken      (clken),
        .i_demod_ena  (ena),
        .i_sym_start  (ss),
        .i_bpsk_in    (bpsk),
        .i_ref_sine   (refs),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_sync_err   (sync_err),
        .o_busy       (busy)
`ifdef BPSK_DEMOD_CONF_EN
        ,
        .o_data_weak  (data_weak)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit w;
        int c;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sync_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every data_valid must match the oldest expected decision, bit and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sync_err) sync_cnt++;
        if (data_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                $display("decision: bit=%0d exp=%0d cycle=%0d exp_cycle=%0d", data_out, e.b, cyc, e.c);
                check("dv_bit", int'(data_out), int'(e.b));
                check("dv_cycle", cyc, e.c);
`ifdef BPSK_DEMOD_CONF_EN
                check("dv_weak", int'(data_weak), int'(e.w));
`endif
            end
        end
    end

    function automatic int sine_at(input int n);
        int t[9] = '{0, 6393, 12540, 18205, 23170, 27245, 30274, 32138, 32767};
        int idx, qd, v;
        idx = n % 32;
        qd  = idx % 16;
        v   = (qd <= 8) ? t[qd] : t[16 - qd];
        return (idx < 16) ? v : -v;
    endfunction

    // One accepted sample, then 'gap' strobeless cycles carrying junk and a stray sym_start.
    task automatic drive(input bit s, input int b, input int r, input int gap);
        clken = 1'b1;
        ss    = s;
        bpsk  = b[15:0];
        refs  = r[15:0];
        @(posedge clk); #1;
        repeat (gap) begin
            clken = 1'b0;
            ss    = 1'b1;
            bpsk  = -16'sd32768;
            refs  = 16'sd32767;
            @(posedge clk); #1;
        end
        clken = 1'b0;
        ss    = 1'b0;
    endtask

    // kind 0: constant ref +16384, bpsk = amp. kind 1: full-scale sine, bpsk = +/-ref by sign of amp.
    task automatic send_sym(input int kind, input int amp, input int gap, input int nsamp,
                            input bit eb, input bit ew);
        for (int n = 0; n < nsamp; n++) begin
            int r, b;
            exp_t e;
            if (kind == 0) begin
                r = 16384;
                b = amp;
            end else begin
                r = sine_at(n);
                b = (amp > 0) ? r : -r;
            end
            if (n == SPS - 1) begin
                e.b = eb;
                e.w = ew;
                e.c = cyc + 2;
                q.push_back(e);
            end
            drive(n == 0, b, r, gap);
        end
    endtask

    initial begin
        int s0;
        int pattern[4] = '{1, 0, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_sync_err", int'(sync_err), 0);
        check("rst_busy", int'(busy), 0);

        @(posedge clk); #1;
        rst = 1'b0;
        ena = 1'b1;
        @(posedge clk); #1;
        check("busy_after_ena", int'(busy), 1);

        // sum = 32*8192 = 262144 -> 1; -262144 -> 0; 0 -> tie decides 0
        send_sym(0, 16384, 0, 32, 1'b1, 1'b0);
        send_sym(0, -16384, 0, 32, 1'b0, 1'b0);
        send_sym(0, 0, 0, 32, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++)
            send_sym(1, (pattern[i] != 0) ? 1 : -1, 2, 32, pattern[i] != 0, 1'b0);

        s0 = sync_cnt;
        check("no_sync_err_yet", s0, 0);
        // 10 strong positive samples, then a resync into a weak negative symbol (-32768 total)
        send_sym(0, 16384, 0, 10, 1'b0, 1'b0);
        send_sym(0, -2048, 0, 32, 1'b0, 1'b0);
        check("sync_err_once", sync_cnt - s0, 1);

        send_sym(0, 16384, 0, 32, 1'b1, 1'b0);

        // Drop enable 20 samples into the next symbol.
        send_sym(0, 16384, 0, 20, 1'b0, 1'b0);
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_disable", int'(busy), 0);
        check("data_out_held", int'(data_out), 1);
        ena = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a symbol.
        send_sym(0, 16384, 0, 15, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("arst_data_out", int'(data_out), 0);
        check("arst_valid", int'(data_valid), 0);
        check("arst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("busy_align", int'(busy), 1);

        repeat (40) drive(1'b0, 16384, 16384, 0);
        check("still_align", int'(busy), 1);
        send_sym(0, 16384, 0, 32, 1'b1, 1'b0);

`ifdef BPSK_DEMOD_CONF_EN
        // +16 * 16384 >>> 15 = 8 per sample, sum = 256 -> 1, weak
        send_sym(0, 16, 0, 32, 1'b1, 1'b1);
        send_sym(0, 16384, 0, 32, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bpsk_demodulator.md
Name: bpsk_demodulator

Overview:
- Coherent BPSK receiver. It is the receive-side counterpart of the sine-generator/mixer modulator datapath.
- Multiplies incoming signed BPSK samples by a locally generated, phase-aligned reference sine.
- Integrates the products over one symbol period and slices the sign of the sum into a recovered data bit.
- Sits between the sample source (ADC/channel model) and the bit-level controller. Emits one data bit plus a valid pulse per symbol.

Parameters:
- DATA_W, 16: width of bpsk_in and ref_sine (signed, two's complement).
- SPS, 32: samples per symbol; legal range 2..1024.
- PROD_SHIFT, 15: arithmetic right shift applied to each product before accumulation.
- ACC_W, 32: accumulator width. Must be >= 2*DATA_W-PROD_SHIFT+clog2(SPS)+1; no saturation logic.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clken  in  1  sample strobe; bpsk_in/ref_sine/sym_start are valid only when high
- demod_ena  in  1  enable; low forces IDLE
- sym_start  in  1  marks sample 0 of a symbol; qualified by clken
- bpsk_in  in  DATA_W  received signed sample
- ref_sine  in  DATA_W  local signed reference sample, aligned with bpsk_in
- data_out  out  1  recovered bit, held until next decision
- data_valid  out  1  one-cycle pulse per decided symbol
- sync_err  out  1  one-cycle pulse on premature sym_start
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, any time): state=IDLE, acc=0, cnt=0, prod=0, prod_vld=0. data_out=0, data_valid=0, sync_err=0, busy=0.
- FSM states: IDLE, ALIGN, INTEGRATE.
  - IDLE -> ALIGN when demod_ena=1.
  - ALIGN -> INTEGRATE on a cycle with clken & sym_start; that sample is sample 0. All other samples in ALIGN are ignored.
  - INTEGRATE stays until demod_ena=0.
  - Any state -> IDLE on the edge after demod_ena=0. acc, cnt and prod_vld are cleared; no data_valid is issued for the partial symbol.
- Stage 1 (product):
  - On each accepted sample (clken & INTEGRATE, or the ALIGN->INTEGRATE sample), register prod = bpsk_in*ref_sine as a full 2*DATA_W signed value.
  - Set prod_vld=1 and tag the product with last = (cnt==SPS-1).
  - cnt increments mod SPS per accepted sample.
- Stage 2 (accumulate/decide), on the cycle where prod_vld=1:
  - sum = acc + sign_extend(prod >>> PROD_SHIFT).
  - If not last: acc <= sum.
  - If last: acc <= 0; data_out <= (sum > 0) ? 1 : 0, so sum==0 decides 0; data_valid <= 1 for exactly one cycle.
- Latency: last sample accepted at edge E; data_out/data_valid update at edge E+1; data_valid is high between E+1 and E+2.
- Bit polarity: data=1 is transmitted as +sine and data=0 as -sine, matching the modulator.
- Consecutive symbols with clken tied high are back-to-back: no bubble, one data_valid every SPS cycles.
- Resync: sym_start & clken in INTEGRATE with cnt != 0:
  - sync_err pulses one cycle.
  - The partial acc is discarded (stage 2 for the in-flight product is suppressed).
  - The current sample becomes sample 0 and cnt=1 after the edge.
  - No data_valid is issued for the aborted symbol.
- sym_start with cnt==0 in INTEGRATE is the expected case and is not an error.
- clken=0 cycles: no product is taken and cnt holds. The pending stage-2 product still completes.
- busy is combinational from state.

Optional Feature:
- Macro: BPSK_DEMOD_CONF_EN.
- Defined:
  - Adds parameter CONF_THRESH (default 1024) and output port data_weak (1 bit, reset 0).
  - data_weak is updated at the same edge as data_out: 1 when |sum| < CONF_THRESH, else 0.
- Undefined: the port and parameter are absent and there is no comparator logic. All other behaviour is identical.

Test Plan:
- Reset release, demod_ena=1, SPS=32, clken tied high; ref_sine=+16384 constant, bpsk_in=+16384 for 32 samples from sym_start -> single data_valid pulse 1 cycle after the 32nd sample, data_out=1; sum=32*8192=262144.
- Same setup with bpsk_in=-16384 -> data_out=0. Then with bpsk_in=0 -> sum=0, data_out=0 (tie decides 0).
- Bit pattern 1,0,1,1 modulated onto a 32-sample full-scale sine, clken every 3rd cycle -> data_valid exactly 4 times at the correct spacing, bits 1,0,1,1.
- sym_start reasserted at cnt=10 -> sync_err pulses once, no data_valid for the aborted symbol; the next decision occurs 32 samples after the resync sample.
- demod_ena dropped at cnt=20 and reset asserted mid-symbol -> busy=0 next edge, no data_valid; after reset all outputs are 0 and ALIGN waits for the next sym_start.
- With BPSK_DEMOD_CONF_EN, CONF_THRESH=1024: bpsk_in=+16 against ref +16384 -> sum=256, data_out=1, data_weak=1. Full-scale input -> data_weak=0.
